dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Data-memory responder for the RV32I core. It is the memory-side end of the load/store path: it accepts one request at a time over a req/gnt handshake and applies byte-enabled writes to a word-organised RAM. It returns the raw 32-bit word on reads and reports one response per accepted request through rvalid/err. Lane extraction and sign extension stay in the core's load/store unit; this block only deals in aligned words plus byte enables.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; word index = addr_i[31:2]
WAIT_CYCLES, 1, extra wait states between acceptance and response (legal 0..7)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_n_i  input  1  asynchronous active-low reset
req_i  input  1  request valid; hold all request fields stable until granted
we_i  input  1  1 = store, 0 = load
be_i  input  4  byte enables; bit k selects lane k = bits [8k+7:8k]
addr_i  input  32  byte address; bits [1:0] ignored (lanes come from be_i)
wdata_i  input  32  store data, already placed in the correct lanes
gnt_o  output  1  request accepted this cycle when req_i && gnt_o
rvalid_o  output  1  one-cycle response strobe, one per accepted request
rdata_o  output  32  read word, valid when rvalid_o && !we of that request
err_o  output  1  response is an error, qualified by rvalid_o

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_n_i is asynchronous, active-low.
- Reset values: state IDLE, gnt_o=0 during reset, rvalid_o=0, err_o=0, rdata_o=0, wait counter=0. RAM contents are not reset.
- FSM states:
  - IDLE: gnt_o=1 (decoded from the state register, no combinational path from req_i). On req_i, latch addr/we/be/wdata, go to WAIT if WAIT_CYCLES>0 else RESP, and load the counter with WAIT_CYCLES-1.
  - WAIT: gnt_o=0. Decrement the counter each cycle; at 0 go to RESP.
  - RESP: rvalid_o=1 for exactly this cycle, gnt_o=0, then return to IDLE.
- Latency: request accepted in cycle N, rvalid_o in cycle N+1+WAIT_CYCLES, next grant in cycle N+2+WAIT_CYCLES.
- Commit point: the store write and the read capture happen on the clock edge that enters RESP. A store is therefore visible to any later read, and read-after-write returns the new data.
- Legal be_i values: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other value, including 0000 and 0110, is an error.
- Range check: word index >= DEPTH_WORDS is an error. Compare the full addr_i[31:2]; there is no wrap-around aliasing.
- Error response: err_o=1, rdata_o=0, RAM unchanged, still exactly one rvalid_o pulse.
- Store: only the enabled lanes change; other lanes keep their value.
- Load: rdata_o = the full stored word regardless of be_i. be_i is used only for the legality check.
- Store response: rdata_o=0, err_o=0.
- req_i while not granted: ignored; the requester keeps it asserted, and it is accepted in the next IDLE.
- rdata_o/err_o: hold their last value after rvalid_o deasserts until the next response.
- Reset mid-operation: asserting rst_n_i in WAIT or RESP aborts the transaction. Any store not yet at the RESP-entry edge is discarded, no rvalid_o is issued, and the block restarts in IDLE.

Decomposition:
- Shared package dmem_pkg:
  - FSM state encoding (ST_IDLE, ST_WAIT, ST_RESP)
  - legal byte-enable constants and a be_legal function
  - WORD_W=32, BE_W=4
- Sub-module dmem_bank: four 8-bit-wide RAM arrays, DEPTH_WORDS deep, with per-lane write enable and a synchronous read port. dmem_responder holds the FSM, the counter, the range/be checks and the response registers.

Test Plan:
- Reset, idle: after reset release, gnt_o=1, rvalid_o=0, err_o=0, rdata_o=0. Pulse rst_n_i low asynchronously mid-cycle -> all outputs clear immediately.
- SW/LW, WAIT_CYCLES=1: store we=1 be=1111 addr=0x10 wdata=0xDEADBEEF accepted at N -> rvalid_o at N+2 with err=0. Load addr=0x10 -> rdata_o=0xDEADBEEF.
- Byte/half stores: start with the word at 0x20 = 0x00000000.
  - store be=0100 wdata=0x00AB0000 -> word reads 0x00AB0000
  - then store be=0011 wdata=0x00001234 -> word reads 0x00AB1234
- Errors:
  - load addr=0x1000 (index 1024) -> rvalid_o=1, err_o=1, rdata_o=0
  - store be=0110 to 0x20 -> err_o=1, word still 0x00AB1234
- Back-to-back, WAIT_CYCLES=0: hold req_i high for 3 loads -> grants every 2nd cycle, each rvalid_o exactly 1 cycle after its grant, 3 responses total, in order.
- Reset mid-store, WAIT_CYCLES=3: store 0x55555555 to 0x40 (previously 0x11111111), assert reset in WAIT -> no rvalid_o. After reset, load 0x40 -> 0x11111111.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// bus widths and the set of byte-enable patterns a load/store may carry.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [BE_W-1:0] BE_B0   = 4'b0001;
  localparam logic [BE_W-1:0] BE_B1   = 4'b0010;
  localparam logic [BE_W-1:0] BE_B2   = 4'b0100;
  localparam logic [BE_W-1:0] BE_B3   = 4'b1000;
  localparam logic [BE_W-1:0] BE_H0   = 4'b0011;
  localparam logic [BE_W-1:0] BE_H1   = 4'b1100;
  localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

  // Only naturally aligned byte, halfword and word accesses are meaningful.
  function automatic logic be_legal(input logic [BE_W-1:0] be);
    logic ok;
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_WORD: ok = 1'b1;
      default:                                           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised RAM built from four byte lanes; per-lane write enable and a
// synchronous read port (data appears after the edge on which re_i is high).
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [AW-1:0]     idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  for (genvar k = 0; k < BE_W; k++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
      if (we_i && be_i[k]) begin
        mem[idx_i] <= wdata_i[8*k +: 8];
      end
      if (re_i) begin
        rdata_q <= mem[idx_i];
      end
    end

    assign rdata_o[8*k +: 8] = rdata_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the load/store path: one request at a time over req/gnt,
// response strobe WAIT_CYCLES+1 cycles after acceptance; no grant while busy.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [31:0]       addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              err_o
);

  localparam int               AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int               IDX_W     = 30;
  localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(DEPTH_WORDS);
  localparam logic [2:0]       CNT_INIT  = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic                rd_ok_q, rd_ok_d;

  logic                accept;
  logic                enter_resp;
  logic                sel_err;
  logic                we_sel;
  logic [BE_W-1:0]     be_sel;
  logic [IDX_W-1:0]    idx_sel;
  logic [WORD_W-1:0]   wdata_sel;
  logic                bank_we;
  logic                bank_re;
  logic [WORD_W-1:0]   bank_rdata;

  // Byte offset is carried by be_i, so the low address bits are never consulted.
  logic                unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    be_d       = be_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rd_ok_d    = rd_ok_q;
    we_sel     = we_q;
    be_sel     = be_q;
    idx_sel    = idx_q;
    wdata_sel  = wdata_q;
    enter_resp = 1'b0;
    accept     = (state_q == ST_IDLE) && gnt_q && req_i;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = we_i;
          be_d    = be_i;
          idx_d   = addr_i[31:2];
          wdata_d = wdata_i;
          if (WAIT_CYCLES == 0) begin
            // With no wait states the acceptance edge is also the commit edge.
            state_d    = ST_RESP;
            enter_resp = 1'b1;
            we_sel     = we_i;
            be_sel     = be_i;
            idx_sel    = addr_i[31:2];
            wdata_sel  = wdata_i;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    sel_err = !be_legal(be_sel) || (idx_sel >= IDX_LIMIT);
    bank_we = enter_resp && we_sel && !sel_err;
    bank_re = enter_resp && !we_sel && !sel_err;

    if (enter_resp) begin
      err_d   = sel_err;
      rd_ok_d = !we_sel && !sel_err;
    end

    gnt_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  dmem_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_bank (
    .clk_i   (clk_i),
    .we_i    (bank_we),
    .re_i    (bank_re),
    .be_i    (be_sel),
    .idx_i   (idx_sel[AW-1:0]),
    .wdata_i (wdata_sel),
    .rdata_o (bank_rdata)
  );

  // The bank output register holds across idle cycles; rd_ok_q masks it to
  // zero for stores, errors and after reset.
  assign gnt_o    = gnt_q;
  assign rvalid_o = (state_q == ST_RESP);
  assign err_o    = err_q;
  assign rdata_o  = rd_ok_q ? bank_rdata : '0;

endmodule
